// File: rtl/shift_register_ctrl.sv
// shift_register_ctrl
//   Serial/parallel shift register for the I2C byte engine. A load starts a
//   frame; each accepted shift_en strobe moves one bit out of shift_out and
//   one bit in from shift_in. After REG_WIDTH accepted strobes the frame ends,
//   busy drops and done pulses for one cycle.
//
//   Optional feature, macro SHIFT_REG_PARITY_EN: adds output `parity`, the
//   XOR of every bit accepted on shift_in during the current frame.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   load       in   parallel-load strobe, starts a frame (beats shift_en)
//   load_data  in   [REG_WIDTH]  value captured on load
//   shift_en   in   one-cycle shift strobe, honoured only while busy
//   shift_in   in   serial input bit
//   shift_out  out  serial output bit (MSB or LSB of par_out)
//   par_out    out  [REG_WIDTH] register contents
//   bit_cnt    out  [CNT_W] bits shifted in the current frame
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the final shift of a frame
//   parity     out  running XOR of received bits (SHIFT_REG_PARITY_EN only)
module shift_register_ctrl #(
  parameter int                   REG_WIDTH   = 8,
  parameter logic [REG_WIDTH-1:0] RESET_VALUE = '0,
  parameter bit                   MSB_FIRST   = 1'b1,
  localparam int                  CNT_W       = $clog2(REG_WIDTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [REG_WIDTH-1:0] load_data,
  input  logic                 shift_en,
  input  logic                 shift_in,
  output logic                 shift_out,
  output logic [REG_WIDTH-1:0] par_out,
  output logic [CNT_W-1:0]     bit_cnt,
  output logic                 busy,
`ifdef SHIFT_REG_PARITY_EN
  output logic                 parity,
`endif
  output logic                 done
);

  logic [REG_WIDTH-1:0] par_q, par_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept;

  // A strobe only counts while a frame is open; after the final bit the
  // register freezes until the next load (no wrap-around).
  assign accept = shift_en && !load && busy_q;

  always_comb begin
    par_d  = par_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (load) begin
      par_d  = load_data;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (accept) begin
      if (MSB_FIRST) par_d = {par_q[REG_WIDTH-2:0], shift_in};
      else           par_d = {shift_in, par_q[REG_WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(REG_WIDTH-1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q  <= RESET_VALUE;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

`ifdef SHIFT_REG_PARITY_EN
  logic par_bit_q, par_bit_d;

  always_comb begin
    par_bit_d = par_bit_q;
    if (load)        par_bit_d = 1'b0;
    else if (accept) par_bit_d = par_bit_q ^ shift_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_bit_q <= 1'b0;
    else     par_bit_q <= par_bit_d;
  end

  assign parity = par_bit_q;
`endif

  assign par_out   = par_q;
  assign bit_cnt   = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign shift_out = MSB_FIRST ? par_q[REG_WIDTH-1] : par_q[0];

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) share one
// stimulus stream. The stimulus process advances a frame-level model and
// pushes the expected outputs; a negedge monitor pops and compares.
module tb_shift_register_ctrl;
  localparam int W = 8;
  localparam int CW = $clog2(W+1);

  logic gclk = 1'b0;
  logic rst = 1'b1, load = 1'b0, shift_en = 1'b0, shift_in = 1'b0;
  logic [W-1:0] load_data = '0;

  logic           so_m, so_l, busy_m, busy_l, done_m, done_l;
  logic [W-1:0]   po_m, po_l;
  logic [CW-1:0]  bc_m, bc_l;
`ifdef SHIFT_REG_PARITY_EN
  logic           pa_m, pa_l;
`endif

  always #5 gclk = ~gclk;

  shift_register_ctrl #(.REG_WIDTH(W), .RESET_VALUE(8'hA5), .MSB_FIRST(1'b1)) u_msb (
    .clk(gclk), .rst(rst), .load(load), .load_data(load_data),
    .shift_en(shift_en), .shift_in(shift_in), .shift_out(so_m),
    .par_out(po_m), .bit_cnt(bc_m), .busy(busy_m),
`ifdef SHIFT_REG_PARITY_EN
    .parity(pa_m),
`endif
    .done(done_m));

  shift_register_ctrl #(.REG_WIDTH(W), .RESET_VALUE(8'hA5), .MSB_FIRST(1'b0)) u_lsb (
    .clk(gclk), .rst(rst), .load(load), .load_data(load_data),
    .shift_en(shift_en), .shift_in(shift_in), .shift_out(so_l),
    .par_out(po_l), .bit_cnt(bc_l), .busy(busy_l),
`ifdef SHIFT_REG_PARITY_EN
    .parity(pa_l),
`endif
    .done(done_l));

  typedef struct {
    int unsigned par_m, par_l, cnt;
    bit          busy, done, parity;
  } exp_t;

  exp_t exp_q[$];
  int total = 0, bad = 0;

  // Frame-level model: loaded word, received bits in arrival order.
  int unsigned m_ld, m_n, m_rx_m, m_rx_l, m_ones;
  bit          m_busy, m_done;

  function automatic void model_reset();
    m_ld = 32'hA5; m_n = 0; m_rx_m = 0; m_rx_l = 0; m_ones = 0;
    m_busy = 0; m_done = 0;
  endfunction

  function automatic void model_edge(bit ld, int unsigned d, bit sh, bit b);
    m_done = 0;
    if (ld) begin
      m_ld = d; m_n = 0; m_rx_m = 0; m_rx_l = 0; m_ones = 0; m_busy = 1;
    end else if (sh && m_busy) begin
      m_rx_m = (m_rx_m << 1) | b;      // first bit ends up highest
      m_rx_l = m_rx_l | (b << m_n);    // first bit ends up lowest
      m_ones += b;
      m_n++;
      if (m_n == W) begin m_busy = 0; m_done = 1; end
    end
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.par_m  = ((m_ld << m_n) | m_rx_m) & 32'hFF;
    e.par_l  = ((m_ld >> m_n) | (m_rx_l << (W - m_n))) & 32'hFF;
    e.cnt    = m_n;
    e.busy   = m_busy;
    e.done   = m_done;
    e.parity = m_ones[0];
    return e;
  endfunction

  task automatic chk(string name, int unsigned act, int unsigned expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge gclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("par_m", po_m, e.par_m);
      chk("par_l", po_l, e.par_l);
      chk("cnt_m", bc_m, e.cnt);
      chk("cnt_l", bc_l, e.cnt);
      chk("busy_m", busy_m, e.busy);
      chk("busy_l", busy_l, e.busy);
      chk("done_m", done_m, e.done);
      chk("done_l", done_l, e.done);
      chk("sout_m", so_m, e.par_m[W-1]);
      chk("sout_l", so_l, e.par_l[0]);
`ifdef SHIFT_REG_PARITY_EN
      chk("parity_m", pa_m, e.parity);
      chk("parity_l", pa_l, e.parity);
`endif
    end
  end

  // One cycle: let the edge act on the current inputs, then drive new ones.
  // A newly asserted rst resets the model immediately (asynchronous), so the
  // following negedge check sees reset values before any clock edge.
  task automatic step(bit r, bit ld, logic [W-1:0] d, bit sh, bit b);
    @(posedge gclk);
    if (rst) model_reset();
    else     model_edge(load, load_data, shift_en, shift_in);
    #1;
    rst = r; load = ld; load_data = d; shift_en = sh; shift_in = b;
    if (r) model_reset();
    exp_q.push_back(model_exp());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  task automatic recv(logic [W-1:0] v);
    step(0, 1, '0, 0, 0);
    for (int i = W-1; i >= 0; i--) step(0, 0, '0, 1, v[i]);
    idle(2);
  endtask

  initial begin
    logic [W-1:0] rxb;
    model_reset();
    step(1, 0, '0, 0, 0);
    idle(2);

    // TX: C3 out with zeros in
    step(0, 1, 8'hC3, 0, 0);
    for (int i = 0; i < W; i++) step(0, 0, '0, 1, 0);
    idle(3);

    // RX: 1,0,1,1,0,0,1,0 -> LSB-first instance assembles 4D
    rxb = 8'b0100_1101;
    step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < W; i++) step(0, 0, '0, 1, rxb[i]);
    idle(2);

    // Non-consecutive strobes, then strobes after done
    step(0, 1, 8'h96, 0, 0);
    for (int i = 0; i < W; i++) begin
      step(0, 0, '0, 1, i[0]);
      idle(3);
    end
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 1);
    idle(2);

    // Load beats shift at bit_cnt=5
    step(0, 1, 8'h3C, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 1);
    step(0, 1, 8'h5A, 1, 1);
    idle(3);

    // Reset mid-frame: async values, no done afterwards
    step(0, 1, 8'hE7, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0);
    step(1, 0, '0, 1, 0);
    step(1, 0, '0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1, 1);

    // Parity frames
    recv(8'hB1);
    recv(8'h07);
    step(0, 1, 8'hFF, 0, 0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
           W'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    idle(3);

    @(negedge gclk);
    @(negedge gclk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_register_ctrl.md
Name: shift_register_ctrl

Overview:
- Parametrised serial/parallel shift register with parallel load, selectable shift direction, bit counter and completion flag.
- Serves as the data shifter of the I2C byte engine: the same instance transmits a loaded byte on the serial output and assembles a received byte from the serial input.
- Successor to the fixed-width shifter. It adds load, direction control, frame counting and a done pulse.

Parameters:
- REG_WIDTH, 8, register width and frame length in bits; must be >= 2.
- RESET_VALUE, 0, value of par_out after reset.
- MSB_FIRST, 1: shift toward MSB, so the MSB leaves first (I2C order). 0: shift toward LSB, so the LSB leaves first.
- Local CNT_W = $clog2(REG_WIDTH+1), width of bit_cnt.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  parallel-load strobe; starts a frame.
- load_data  input  REG_WIDTH  value captured on load.
- shift_en  input  1  one-cycle strobe that shifts one bit.
- shift_in  input  1  serial input bit.
- shift_out  output  1  serial output bit; combinational from par_out.
- par_out  output  REG_WIDTH  register contents.
- bit_cnt  output  CNT_W  number of bits shifted in the current frame.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the last bit of a frame.

Behaviour:
- Reset (asynchronous, while rst=1): par_out=RESET_VALUE, bit_cnt=0, busy=0, done=0. Reset asserted mid-frame aborts the frame immediately; no done pulse is produced.
- done defaults to 0 every cycle unless set by the final-shift rule below.
- Priority each cycle: load, then shift_en.
- load=1:
  - par_out<=load_data, bit_cnt<=0, busy<=1, done<=0.
  - A load while busy=1 restarts the frame and discards the partial frame.
  - A load in the same cycle as shift_en takes priority; the shift is dropped.
- shift_en=1, load=0, busy=1:
  - MSB_FIRST=1: par_out<={par_out[REG_WIDTH-2:0], shift_in}.
  - MSB_FIRST=0: par_out<={shift_in, par_out[REG_WIDTH-1:1]}.
  - bit_cnt<=bit_cnt+1.
- Final shift (shift_en=1, load=0, busy=1, bit_cnt==REG_WIDTH-1):
  - bit_cnt becomes REG_WIDTH, busy<=0, done<=1.
  - done is high for exactly the one cycle after that final shift edge.
  - par_out then holds the complete received word.
- shift_en=1 with busy=0: ignored; par_out and bit_cnt hold. There is no wrap-around.
- bit_cnt holds REG_WIDTH after a frame until the next load or reset.
- shift_out:
  - par_out[REG_WIDTH-1] when MSB_FIRST=1, else par_out[0].
  - Valid from the cycle after load; it changes only after a shift edge.
- Latency: a REG_WIDTH-bit frame completes after exactly REG_WIDTH accepted shift_en strobes. done rises on the edge of the last strobe; strobes need not be consecutive.
- Receive use: load all zeros, then shift REG_WIDTH bits.

Optional Feature:
- Macro: SHIFT_REG_PARITY_EN.
- When defined:
  - Adds output port parity (1 bit) and a register that holds the XOR of every bit accepted on shift_in during the current frame.
  - The register clears to 0 on rst and on load, and updates only on accepted shifts.
  - After done, parity equals the even parity of the received word.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-frame with RESET_VALUE=8'hA5 -> par_out=8'hA5, bit_cnt=0, busy=0 and done=0 asynchronously; no done pulse after release.
- TX, MSB_FIRST=1: load 8'hC3, then 8 consecutive shift_en with shift_in=0 -> shift_out sequence 1,1,0,0,0,0,1,1; done pulses once after the 8th strobe; bit_cnt=8; busy=0; par_out=8'h00.
- RX, MSB_FIRST=0: load 8'h00, shift in 1,0,1,1,0,0,1,0 -> par_out=8'h4D, done pulses once.
- Non-consecutive strobes: load, then strobes with 3 idle cycles between each -> done only after the 8th strobe; extra strobes after done -> par_out and bit_cnt unchanged.
- Load priority: load 8'h5A in the same cycle as shift_en at bit_cnt=5 -> par_out=8'h5A, bit_cnt=0, busy=1, no done.
- SHIFT_REG_PARITY_EN: receive 8'hB1 (four ones) -> parity=0; receive 8'h07 -> parity=1; a new load clears parity to 0.
